psum_adder_node: RTL and testbench

Clocked NoC endpoint that sits directly downstream of the five convolution PEs. Each PE sends type-2'b10 partial-sum packets round-robin to the seven adder addresses. This block collects one partial sum from each of the five PEs for the same output neuron, sums them, and integrates the result into that neuron's membrane potential. It then thresholds the potential and emits one spike/potential packet per neuron toward the output memory.

---
 rtl/psum_pkg.sv | 81 ++++++++
 rtl/psum_adder_node_vmem_bank.sv | 39 +++
 rtl/psum_adder_node.sv | 184 ++++++++++++++++++
 tb/tb_psum_adder_node.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// psum_pkg
//   Shared definitions for the partial-sum adder nodes of the convolution NoC:
//   node addresses, packet type codes, packet field positions, the adder FSM
//   state encoding and the source-address to slot decoder.
package psum_pkg;

  // Convolution PE addresses (sources of psum packets)
  localparam logic [3:0] PE0_ADDR = 4'b0001;
  localparam logic [3:0] PE1_ADDR = 4'b0101;
  localparam logic [3:0] PE2_ADDR = 4'b0011;
  localparam logic [3:0] PE3_ADDR = 4'b0111;
  localparam logic [3:0] PE4_ADDR = 4'b1100;

  // Adder node addresses (psum destinations, round-robin)
  localparam logic [3:0] ADDER0_ADDR = 4'b0010;
  localparam logic [3:0] ADDER1_ADDR = 4'b0100;
  localparam logic [3:0] ADDER2_ADDR = 4'b0110;
  localparam logic [3:0] ADDER3_ADDR = 4'b1001;
  localparam logic [3:0] ADDER4_ADDR = 4'b1010;
  localparam logic [3:0] ADDER5_ADDR = 4'b1011;
  localparam logic [3:0] ADDER6_ADDR = 4'b1101;

  // Output memory address
  localparam logic [3:0] OUT_MEM_ADDR = 4'b1000;

  // Packet type codes
  localparam logic [1:0] PKT_IFMAP  = 2'b00;
  localparam logic [1:0] PKT_FILTER = 2'b01;
  localparam logic [1:0] PKT_PSUM   = 2'b10;
  localparam logic [1:0] PKT_SPIKE  = 2'b11;

  // Packet field positions
  localparam int DEST_HI   = 63;
  localparam int DEST_LO   = 60;
  localparam int SRC_HI    = 59;
  localparam int SRC_LO    = 56;
  localparam int TYPE_HI   = 55;
  localparam int TYPE_LO   = 54;
  localparam int TS_HI     = 37;
  localparam int TS_LO     = 32;
  localparam int IDX_HI    = 31;
  localparam int IDX_LO    = 24;
  localparam int SPIKE_BIT = 16;
  localparam int VNEW_HI   = 15;
  localparam int VNEW_LO   = 0;

  // Adder FSM encoding
  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_ADD     = 2'd1;
  localparam logic [1:0] ST_SEND    = 2'd2;

  typedef enum logic [1:0] {
    COLLECT = ST_COLLECT,
    ADD     = ST_ADD,
    SEND    = ST_SEND
  } psumStateT;

  typedef struct packed {
    logic       hit;
    logic [2:0] slot;
  } slotSelT;

  // Map a PE source address to its slot; hit=0 for any non-PE source
  function automatic slotSelT srcToSlot(input logic [3:0] src);
    slotSelT sel;
    sel.hit = 1'b1;
    case (src)
      PE0_ADDR: sel.slot = 3'd0;
      PE1_ADDR: sel.slot = 3'd1;
      PE2_ADDR: sel.slot = 3'd2;
      PE3_ADDR: sel.slot = 3'd3;
      PE4_ADDR: sel.slot = 3'd4;
      default: begin
        sel.hit  = 1'b0;
        sel.slot = 3'd0;
      end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/psum_adder_node_vmem_bank.sv
// vmem_bank
//   Membrane-potential register file: DEPTH x WIDTH, one asynchronous read
//   port and one synchronous write port, cleared by the asynchronous reset.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rdAddr/rdData   combinational read port
//   wrEn/wrAddr/wrData  write port, applied on the rising clock edge
module vmem_bank
  import psum_pkg::*;
#(
  parameter int DEPTH = 63,
  parameter int WIDTH = 16,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdData = mem[rdAddr];

  // Storage: cleared on reset, single write per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

endmodule

// File: rtl/psum_adder_node.sv
// psum_adder_node
//   NoC endpoint behind the five convolution PEs. Collects one partial sum
//   from each PE for the current neuron, adds them, integrates the result into
//   the neuron's membrane potential, thresholds it and emits one spike packet
//   per neuron toward the output memory.
// Ports:
//   clk, rst                              clock, asynchronous active-high reset
//   pkt_in_valid/pkt_in_ready/pkt_in_data   incoming psum packets
//   pkt_out_valid/pkt_out_ready/pkt_out_data outgoing spike/potential packets
//   ts_done                               pulse after the last neuron of a timestep is sent
//   drop                                  pulse after a malformed packet is consumed
module psum_adder_node
  import psum_pkg::*;
#(
  parameter logic [3:0]  ADDER_ADDRESS = 4'b0010,
  parameter logic [3:0]  OUT_ADDRESS   = 4'b1000,
  parameter int          NUM_NEURONS   = 63,
  parameter logic [15:0] THRESHOLD     = 16'd64,
  parameter int          PSUM_WIDTH    = 13,
  parameter int          VMEM_WIDTH    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_in_valid,
  output logic        pkt_in_ready,
  input  logic [63:0] pkt_in_data,
  output logic        pkt_out_valid,
  input  logic        pkt_out_ready,
  output logic [63:0] pkt_out_data,
  output logic        ts_done,
  output logic        drop
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  psumStateT              state;
  logic [4:0]             slotValid;
  logic [PSUM_WIDTH-1:0]  slotVal [5];
  logic [VMEM_WIDTH-1:0]  sumR;
  logic [IDX_W-1:0]       index;
  logic [5:0]             timestep;

  slotSelT                inSel;
  logic                   inIsPsum;
  logic                   inAccept;
  logic                   unusedInBits;
  logic [VMEM_WIDTH-1:0]  slotSum;
  logic [VMEM_WIDTH-1:0]  vmemRd;
  logic [VMEM_WIDTH:0]    thrExt;
  logic [VMEM_WIDTH:0]    vSum;
  logic [VMEM_WIDTH:0]    vThr;
  logic [VMEM_WIDTH-1:0]  vNew;
  logic                   spike;
  logic [63:0]            outPkt;

  // Destination and padding bits of incoming packets carry nothing this node uses
  assign unusedInBits = ^{pkt_in_data[DEST_HI:DEST_LO], pkt_in_data[TYPE_LO-1:PSUM_WIDTH]};

  assign thrExt   = (VMEM_WIDTH + 1)'(THRESHOLD);
  assign inAccept = pkt_in_valid && pkt_in_ready;

  // Input decode and ready: malformed packets are always sunk, psums wait for their slot
  always_comb begin
    inSel    = srcToSlot(pkt_in_data[SRC_HI:SRC_LO]);
    inIsPsum = (pkt_in_data[TYPE_HI:TYPE_LO] == PKT_PSUM) && inSel.hit;
    if (inIsPsum) begin
      pkt_in_ready = !slotValid[inSel.slot];
    end else begin
      pkt_in_ready = 1'b1;
    end
  end

  // Five-way sum; 5 x 8191 fits in 16 bits so no carry is lost
  always_comb begin
    slotSum = {VMEM_WIDTH{1'b0}};
    for (int i = 0; i < 5; i++) begin
      slotSum = slotSum + VMEM_WIDTH'(slotVal[i]);
    end
  end

  // Integrate, threshold and saturate the neuron's potential
  always_comb begin
    vSum = {1'b0, vmemRd} + {1'b0, sumR};
    if (vSum >= thrExt) begin
      spike = 1'b1;
      vThr  = vSum - thrExt;
    end else begin
      spike = 1'b0;
      vThr  = vSum;
    end
    if (vThr[VMEM_WIDTH]) begin
      vNew = {VMEM_WIDTH{1'b1}};
    end else begin
      vNew = vThr[VMEM_WIDTH-1:0];
    end
  end

  // Outgoing packet image
  always_comb begin
    outPkt                    = 64'd0;
    outPkt[DEST_HI:DEST_LO]   = OUT_ADDRESS;
    outPkt[SRC_HI:SRC_LO]     = ADDER_ADDRESS;
    outPkt[TYPE_HI:TYPE_LO]   = PKT_SPIKE;
    outPkt[TS_HI:TS_LO]       = timestep;
    outPkt[IDX_HI:IDX_LO]     = 8'(index);
    outPkt[SPIKE_BIT]         = spike;
    outPkt[VNEW_HI:VNEW_LO]   = 16'(vNew);
  end

  vmem_bank #(
    .DEPTH (NUM_NEURONS),
    .WIDTH (VMEM_WIDTH),
    .AW    (IDX_W)
  ) uVmem (
    .clk    (clk),
    .rst    (rst),
    .rdAddr (index),
    .rdData (vmemRd),
    .wrEn   (state == ADD),
    .wrAddr (index),
    .wrData (vNew)
  );

  // Slot storage, FSM, output packet register and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= COLLECT;
      slotValid     <= 5'd0;
      for (int i = 0; i < 5; i++) begin
        slotVal[i] <= {PSUM_WIDTH{1'b0}};
      end
      sumR          <= {VMEM_WIDTH{1'b0}};
      index         <= {IDX_W{1'b0}};
      timestep      <= 6'd0;
      pkt_out_valid <= 1'b0;
      pkt_out_data  <= 64'd0;
      ts_done       <= 1'b0;
      drop          <= 1'b0;
    end else begin
      drop    <= inAccept && !inIsPsum;
      ts_done <= 1'b0;

      // All slots are full during ADD, so no psum can be accepted on the clear edge
      if (state == ADD) begin
        slotValid <= 5'd0;
      end else if (inAccept && inIsPsum) begin
        slotValid[inSel.slot] <= 1'b1;
        slotVal[inSel.slot]   <= pkt_in_data[PSUM_WIDTH-1:0];
      end

      case (state)
        COLLECT: begin
          if (&slotValid) begin
            sumR  <= slotSum;
            state <= ADD;
          end
        end
        ADD: begin
          pkt_out_data  <= outPkt;
          pkt_out_valid <= 1'b1;
          state         <= SEND;
        end
        SEND: begin
          if (pkt_out_ready) begin
            pkt_out_valid <= 1'b0;
            if (index == LAST_IDX) begin
              index    <= {IDX_W{1'b0}};
              timestep <= timestep + 6'd1;
              ts_done  <= 1'b1;
            end else begin
              index <= index + IDX_W'(1);
            end
            state <= COLLECT;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_adder_node.sv
// Directed, table-driven bench for psum_adder_node.
module tb_psum_adder_node;

  logic        clk;
  logic        rst;
  logic        pkt_in_valid;
  logic        pkt_in_ready;
  logic [63:0] pkt_in_data;
  logic        pkt_out_valid;
  logic        pkt_out_ready;
  logic [63:0] pkt_out_data;
  logic        ts_done;
  logic        drop;

  psum_adder_node dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_in_valid  (pkt_in_valid),
    .pkt_in_ready  (pkt_in_ready),
    .pkt_in_data   (pkt_in_data),
    .pkt_out_valid (pkt_out_valid),
    .pkt_out_ready (pkt_out_ready),
    .pkt_out_data  (pkt_out_data),
    .ts_done       (ts_done),
    .drop          (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0][12:0] ps;
    logic [7:0]       idx;
    logic [5:0]       ts;
    logic             spike;
    logic [15:0]      vnew;
  } vecT;

  int          checks = 0;
  int          errors = 0;
  int          tsDoneCount = 0;
  int          tsDoneIdx = -1;
  int          lastHsIdx = -1;
  int          dropCount = 0;
  logic [63:0] outQ [$];
  vecT         vecs [11];

  function automatic logic [3:0] peOf(input int i);
    case (i)
      0: return 4'b0001;
      1: return 4'b0101;
      2: return 4'b0011;
      3: return 4'b0111;
      4: return 4'b1100;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [63:0] mkIn(input logic [3:0] src, input logic [1:0] typ, input logic [12:0] val);
    return {4'h2, src, typ, 41'd0, val};
  endfunction

  function automatic logic [63:0] mkOut(input logic [5:0] ts, input logic [7:0] idx,
                                        input logic spk, input logic [15:0] vn);
    return {4'h8, 4'h2, 2'b11, 16'h0000, ts, idx, 7'd0, spk, vn};
  endfunction

  function automatic vecT mkVec(input logic [12:0] p0, input logic [12:0] p1, input logic [12:0] p2,
                                input logic [12:0] p3, input logic [12:0] p4, input logic [7:0] idx,
                                input logic [5:0] ts, input logic spk, input logic [15:0] vn);
    vecT v;
    v.ps[0] = p0; v.ps[1] = p1; v.ps[2] = p2; v.ps[3] = p3; v.ps[4] = p4;
    v.idx = idx; v.ts = ts; v.spike = spk; v.vnew = vn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output and pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (pkt_out_valid && pkt_out_ready) begin
      outQ.push_back(pkt_out_data);
      lastHsIdx = int'(pkt_out_data[31:24]);
    end
    if (ts_done) begin
      tsDoneCount++;
      tsDoneIdx = lastHsIdx;
    end
    if (drop) dropCount++;
  end

  task automatic sendPkt(input logic [3:0] src, input logic [1:0] typ, input logic [12:0] val,
                         output int stalls);
    bit ok;
    @(negedge clk);
    pkt_in_data  = mkIn(src, typ, val);
    pkt_in_valid = 1'b1;
    #1;
    stalls = 0;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (pkt_in_ready) begin
        ok = 1'b1;
        break;
      end
      stalls++;
      @(negedge clk);
      #1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: src %b got no ready, required ready within 40 cycles", src);
    end
    pkt_in_valid = 1'b0;
  endtask

  task automatic applySet(input vecT v, input bit skipPe1, input string name);
    int st;
    int lat;
    bit got;
    logic [63:0] o;
    for (int i = 0; i < 5; i++) begin
      if (!(skipPe1 && i == 1)) sendPkt(peOf(i), 2'b10, v.ps[i], st);
    end
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (pkt_out_valid) begin
        got = 1'b1;
        break;
      end
      lat++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no pkt_out_valid, required within 20 cycles", name);
    end else begin
      chk({name, "_latency"}, 64'(lat), 64'd2);
      @(posedge clk);
      #1;
      if (outQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_out: got no handshake, required one output", name);
      end else begin
        o = outQ.pop_front();
        chk({name, "_out"}, o, mkOut(v.ts, v.idx, v.spike, v.vnew));
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish, required finish before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [63:0] held;
    bit stable;

    // Timestep 0, neurons 2..7 and timestep 1, neurons 0..4
    vecs[0]  = mkVec(13'd13, 13'd13, 13'd13, 13'd13, 13'd12, 8'd2, 6'd0, 1'b1, 16'd0);
    vecs[1]  = mkVec(13'd8191, 13'd0, 13'd0, 13'd0, 13'd0, 8'd3, 6'd0, 1'b1, 16'd8127);
    vecs[2]  = mkVec(13'd8191, 13'd8191, 13'd8191, 13'd8191, 13'd8191, 8'd4, 6'd0, 1'b1, 16'd40891);
    vecs[3]  = mkVec(13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 8'd5, 6'd0, 1'b0, 16'd0);
    vecs[4]  = mkVec(13'd12, 13'd12, 13'd12, 13'd12, 13'd15, 8'd6, 6'd0, 1'b0, 16'd63);
    vecs[5]  = mkVec(13'd100, 13'd200, 13'd300, 13'd400, 13'd500, 8'd7, 6'd0, 1'b1, 16'd1436);
    vecs[6]  = mkVec(13'd10, 13'd10, 13'd10, 13'd10, 13'd10, 8'd0, 6'd1, 1'b1, 16'd36);
    vecs[7]  = mkVec(13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 8'd1, 6'd1, 1'b0, 16'd30);
    vecs[8]  = mkVec(13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 8'd2, 6'd1, 1'b0, 16'd0);
    vecs[9]  = mkVec(13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 8'd3, 6'd1, 1'b1, 16'd8063);
    vecs[10] = mkVec(13'd8191, 13'd8191, 13'd8191, 13'd8191, 13'd8191, 8'd4, 6'd1, 1'b1, 16'hFFFF);

    rst           = 1'b1;
    pkt_in_valid  = 1'b0;
    pkt_in_data   = 64'd0;
    pkt_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(pkt_out_valid), 64'd0);
    chk("rst_out_data", pkt_out_data, 64'd0);
    chk("rst_ts_done", 64'(ts_done), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Ready is independent of valid
    pkt_in_data = mkIn(4'b0001, 2'b10, 13'd5);
    #1;
    chk("ready_no_valid", 64'(pkt_in_ready), 64'd1);

    // Malformed packets: wrong type, then non-PE source
    sendPkt(4'b0001, 2'b01, 13'd99, st);
    @(negedge clk); #1;
    chk("drop_type_pulse", 64'(drop), 64'd1);
    @(negedge clk); #1;
    chk("drop_type_end", 64'(drop), 64'd0);
    sendPkt(4'b0010, 2'b10, 13'd77, st);
    @(negedge clk); #1;
    chk("drop_src_pulse", 64'(drop), 64'd1);
    @(negedge clk); #1;
    chk("drop_count", 64'(dropCount), 64'd2);
    pkt_in_data = mkIn(4'b0001, 2'b10, 13'd0);
    #1;
    chk("slot_untouched_ready", 64'(pkt_in_ready), 64'd1);
    chk("no_output_after_drops", 64'(outQ.size()), 64'd0);

    // Neuron 0 with a second PE1 packet that must stall until the slots clear
    sendPkt(4'b0001, 2'b10, 13'd10, st);
    sendPkt(4'b0011, 2'b10, 13'd10, st);
    sendPkt(4'b0111, 2'b10, 13'd10, st);
    sendPkt(4'b1100, 2'b10, 13'd10, st);
    sendPkt(4'b0101, 2'b10, 13'd10, st);
    sendPkt(4'b0101, 2'b10, 13'd20, st);
    chk("pe1_stall_cycles", 64'(st), 64'd2);
    if (outQ.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL n0_out: got no output, required neuron 0 packet");
    end else begin
      chk("n0_out", outQ.pop_front(), mkOut(6'd0, 8'd0, 1'b0, 16'd50));
    end
    applySet(mkVec(13'd1, 13'd20, 13'd2, 13'd3, 13'd4, 8'd1, 6'd0, 1'b0, 16'd30), 1'b1, "n1");

    // Table vectors for neurons 2..7 of timestep 0
    for (int i = 0; i < 6; i++) applySet(vecs[i], 1'b0, $sformatf("ts0_n%0d", i + 2));

    // Remaining neurons of timestep 0 with zero input
    for (int n = 8; n < 63; n++) begin
      if (n == 62) chk("ts_done_not_early", 64'(tsDoneCount), 64'd0);
      applySet(mkVec(13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 8'(n), 6'd0, 1'b0, 16'd0), 1'b0,
               $sformatf("ts0_n%0d", n));
    end
    @(negedge clk); #1;
    chk("ts_done_count", 64'(tsDoneCount), 64'd1);
    chk("ts_done_idx", 64'(tsDoneIdx), 64'd62);

    // Timestep 1 table vectors (wrap, persistence, saturation)
    for (int i = 6; i < 11; i++) applySet(vecs[i], 1'b0, $sformatf("ts1_n%0d", i - 6));
    chk("ts_done_once", 64'(tsDoneCount), 64'd1);

    // Backpressure hold, then reset while the packet is pending
    pkt_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) sendPkt(peOf(i), 2'b10, 13'd1, st);
    stable = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (pkt_out_valid) begin
        stable = 1'b1;
        break;
      end
    end
    chk("bp_valid_seen", 64'(stable), 64'd1);
    held = pkt_out_data;
    chk("bp_out", held, mkOut(6'd1, 8'd5, 1'b0, 16'd5));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (!pkt_out_valid || pkt_out_data !== held) stable = 1'b0;
    end
    chk("bp_hold_stable", 64'(stable), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(pkt_out_valid), 64'd0);
    chk("midrst_data", pkt_out_data, 64'd0);
    chk("midrst_ts_done", 64'(ts_done), 64'd0);
    chk("midrst_no_handshake", 64'(outQ.size()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pkt_out_ready = 1'b1;
    applySet(mkVec(13'd10, 13'd10, 13'd10, 13'd10, 13'd10, 8'd0, 6'd0, 1'b0, 16'd50), 1'b0, "post_rst_n0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
